// File: rtl/wb_sha1_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_sha1_msg_fifo
// Purpose  : Wishbone slave message buffer feeding the SHA-1 core. Firmware
//            pushes 32-bit words into a DEPTH-entry FIFO. The words stream out
//            over a valid/ready port, and every 16th word is flagged block-last.
//            Registers: +0x0 DATA (W), +0x4 STATUS (R), +0x8 CTRL (W).
// Options  : define SHA1_MSG_IRQ_EN to enable the low-water interrupt (irq_o,
//            CTRL[2] / STATUS[19]); otherwise irq_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sha1_msg_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned LOW_WATER = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_valid_o,
    output logic [31:0] m_data_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        irq_o
);

    localparam int unsigned     c_AW        = $clog2(DEPTH);
    localparam int unsigned     c_CW        = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_LOW_WATER = c_CW'(LOW_WATER);
    localparam logic [1:0]      c_OFF_DATA   = 2'd0;
    localparam logic [1:0]      c_OFF_STATUS = 2'd1;
    localparam logic [1:0]      c_OFF_CTRL   = 2'd2;

    logic [31:0]     mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q, count_d;
    logic [3:0]      idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic            ack_q;
    logic [31:0]     rdat_q, rdat_d;

    logic            w_hit, w_acc, w_empty, w_full;
    logic            w_push_req, w_push, w_pop, w_ctrl_wr, w_flush;
    logic [1:0]      w_off;
    logic            w_irq_en_stat;
    logic            w_unused;

`ifdef SHA1_MSG_IRQ_EN
    logic            irq_en_q, irq_en_d;
    logic            irq_q;
    assign w_irq_en_stat = irq_en_q;
    assign irq_o         = irq_q;
    assign w_unused      = ^{wbs_sel_i, wbs_adr_i[1:0]};
`else
    assign w_irq_en_stat = 1'b0;
    assign irq_o         = 1'b0;
    assign w_unused      = ^{wbs_sel_i, wbs_adr_i[1:0], c_LOW_WATER};
`endif

    // Bus decode; an access is accepted only in the cycle that raises ack.
    always_comb begin
        w_off      = wbs_adr_i[3:2];
        w_empty    = (count_q == '0);
        w_full     = (count_q == c_DEPTH);
        w_hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        w_acc      = w_hit & ~ack_q;
        w_push_req = w_acc & wbs_we_i & (w_off == c_OFF_DATA);
        w_push     = w_push_req & ~w_full;   // full judged before any same-cycle pop
        w_ctrl_wr  = w_acc & wbs_we_i & (w_off == c_OFF_CTRL);
        w_flush    = w_ctrl_wr & wbs_dat_i[0];
        w_pop      = ~w_empty & m_ready_i;
    end

    // Next-state for pointers, occupancy, word index, flags and read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        rdat_d   = 32'd0;
        if (w_flush) begin
            // Flush wins over a pop; a push cannot coincide since the bus is busy.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            idx_d    = 4'd0;
        end else begin
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                idx_d    = idx_q + 4'd1;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
        end
        if (w_push_req & w_full) begin
            ovf_d = 1'b1;
        end
        if (w_ctrl_wr & wbs_dat_i[1]) begin
            ovf_d = 1'b0;
        end
        if (w_acc & ~wbs_we_i & (w_off == c_OFF_STATUS)) begin
            rdat_d[8:0] = 9'(count_q);
            rdat_d[16]  = w_empty;
            rdat_d[17]  = w_full;
            rdat_d[18]  = ovf_q;
            rdat_d[19]  = w_irq_en_stat;
        end
    end

    // Control/status registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= 4'd0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            ack_q    <= w_acc;
            rdat_q   <= rdat_d;
        end
    end

`ifdef SHA1_MSG_IRQ_EN
    // Interrupt enable and level interrupt, evaluated against next occupancy.
    always_comb begin
        irq_en_d = irq_en_q;
        if (w_ctrl_wr) begin
            irq_en_d = wbs_dat_i[2];
        end
    end

    // Low-water interrupt register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & (count_d <= c_LOW_WATER);
        end
    end
`endif

    // Message storage; contents need no reset.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wbs_dat_i;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign m_valid_o = ~w_empty;
    assign m_data_o  = w_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign m_last_o  = ~w_empty & (idx_q == 4'hF);

endmodule
`default_nettype wire

// File: tb/tb_wb_sha1_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sha1_msg_fifo
// Purpose  : Directed self-checking bench for wb_sha1_msg_fifo with a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sha1_msg_fifo;

    localparam int          DEPTH     = 16;
    localparam int          LOW_WATER = 4;
    localparam logic [31:0] BASE      = 32'h3000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb   = 1'b0;
    logic        cyc   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'hF;
    logic [31:0] adr   = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic        ready = 1'b0;
    logic        ack, valid, last, irq;
    logic [31:0] dat_o, data;

    always #5 clk = ~clk;

    wb_sha1_msg_fifo #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LOW_WATER (LOW_WATER)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .m_valid_o  (valid),
        .m_data_o   (data),
        .m_last_o   (last),
        .m_ready_i  (ready),
        .irq_o      (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int unsigned m_pops = 0;
    bit          m_ovf = 0, m_irqen = 0, m_ack = 0, m_irq = 0;
    logic [31:0] m_dat = 32'd0;
    bit          mh, ma;
    int          mn;
    logic [1:0]  moff;
    logic [31:0] mrd;
    logic [31:0] popq[$], lastq[$];
    bit          s_valid = 0, s_last = 0;
    logic [31:0] s_data = 32'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_pops = 0; m_ovf = 0; m_irqen = 0; m_ack = 0; m_irq = 0; m_dat = 32'd0;
        end else begin
            if (s_valid && ready) begin
                popq.push_back(s_data);
                if (s_last) lastq.push_back(s_data);
            end
            mh   = stb && cyc && (adr[31:4] == BASE[31:4]);
            ma   = mh && !m_ack;
            mn   = mq.size();
            moff = adr[3:2];
            mrd  = 32'd0;
            if (ma && !we && moff == 2'd1)
                mrd = {12'd0, m_irqen, m_ovf, mn == DEPTH, mn == 0, 7'd0, 9'(mn)};
            if (ma && we && moff == 2'd2 && dat_i[0]) begin
                mq.delete();
                m_pops = 0;
            end else if (mn > 0 && ready) begin
                void'(mq.pop_front());
                m_pops++;
            end
            if (ma && we && moff == 2'd0) begin
                if (mn == DEPTH) m_ovf = 1;
                else             mq.push_back(dat_i);
            end
            if (ma && we && moff == 2'd2) begin
                if (dat_i[1]) m_ovf = 0;
`ifdef SHA1_MSG_IRQ_EN
                m_irqen = dat_i[2];
`endif
            end
            m_ack = ma;
            m_dat = mrd;
`ifdef SHA1_MSG_IRQ_EN
            m_irq = m_irqen && (mq.size() <= LOW_WATER);
`endif
        end
        #1;
        chk("ack",   ack,   m_ack);
        chk("rdata", dat_o, m_dat);
        chk("valid", valid, mq.size() > 0);
        chk("data",  data,  (mq.size() > 0) ? mq[0] : 32'd0);
        chk("last",  last,  (mq.size() > 0) && (m_pops % 16 == 15));
        chk("irq",   irq,   m_irq);
        s_valid = valid;
        s_data  = data;
        s_last  = last;
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic [3:0] off, input bit wr, input logic [31:0] d,
                       input bit pop_during, output logic [31:0] rd);
        int k;
        @(negedge clk);
        stb = 1; cyc = 1; we = wr; adr = BASE + 32'(off); dat_i = d;
        if (pop_during) ready = 1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack && k < 4);
        chk("bus_ack", ack, 1);
        rd = dat_o;
        stb = 0; cyc = 0; we = 0;
        if (pop_during) ready = 0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] r;
        bus(off, 1'b1, d, 1'b0, r);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] r);
        bus(off, 1'b0, 32'd0, 1'b0, r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        // reset
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1;
        rd(4'h4, r);
        chk("rst_status", r, 32'h0001_0000);

        // two words, ordered pop
        wr(4'h0, 32'h6745_2301);
        wr(4'h0, 32'hEFCD_AB89);
        rd(4'h4, r);
        chk("status_cnt2", r, 32'h0000_0002);
        chk("head_word", data, 32'h6745_2301);
        popq.delete();
        ready = 1;
        repeat (2) @(negedge clk);
        ready = 0;
        chk("pop_n", popq.size(), 2);
        if (popq.size() == 2) begin
            chk("pop_first", popq[0], 32'h6745_2301);
            chk("pop_second", popq[1], 32'hEFCD_AB89);
        end
        rd(4'h4, r);
        chk("status_empty", r, 32'h0001_0000);

        // block-last marking and index wrap
        wr(4'h8, 32'h1);
        lastq.delete();
        ready = 1;
        for (int i = 0; i < 16; i++) wr(4'h0, 32'(i));
        repeat (2) @(negedge clk);
        chk("last_n1", lastq.size(), 1);
        if (lastq.size() > 0) chk("last_word15", lastq[0], 32'd15);
        for (int i = 16; i < 32; i++) wr(4'h0, 32'(i));
        repeat (2) @(negedge clk);
        ready = 0;
        chk("last_n2", lastq.size(), 2);
        if (lastq.size() > 1) chk("last_word31", lastq[1], 32'd31);

        // overflow with simultaneous pop
        for (int i = 0; i < 16; i++) wr(4'h0, 32'(100 + i));
        rd(4'h4, r);
        chk("status_full", r, 32'h0002_0010);
        popq.delete();
        bus(4'h0, 1'b1, 32'h0000_DEAD, 1'b1, r);
        rd(4'h4, r);
        chk("status_ovf", r, 32'h0004_000F);
        wr(4'h8, 32'h2);
        rd(4'h4, r);
        chk("status_ovf_clr", r, 32'h0000_000F);
        ready = 1;
        repeat (16) @(negedge clk);
        ready = 0;
        chk("drain_n", popq.size(), 16);
        if (popq.size() == 16) chk("drain_tail", popq[15], 32'd115);
        foreach (popq[i]) if (popq[i] == 32'h0000_DEAD) chk("dead_absent", popq[i], 32'd0);

        // flush with 8 queued and a non-zero word index
        for (int i = 0; i < 11; i++) wr(4'h0, 32'(300 + i));
        ready = 1;
        repeat (3) @(negedge clk);
        ready = 0;
        wr(4'h8, 32'h1);
        chk("flush_valid", valid, 0);
        rd(4'h4, r);
        chk("flush_status", r, 32'h0001_0000);
        lastq.delete();
        ready = 1;
        for (int i = 0; i < 16; i++) wr(4'h0, 32'(200 + i));
        repeat (2) @(negedge clk);
        ready = 0;
        chk("flush_idx_n", lastq.size(), 1);
        if (lastq.size() > 0) chk("flush_idx0", lastq[0], 32'd215);

        // low-water interrupt
        wr(4'h8, 32'h1);
`ifdef SHA1_MSG_IRQ_EN
        wr(4'h8, 32'h4);
        chk("irq_empty", irq, 1);
        for (int i = 0; i < 6; i++) wr(4'h0, 32'(400 + i));
        chk("irq_six", irq, 0);
        rd(4'h4, r);
        chk("irq_status", r, 32'h0008_0006);
        ready = 1;
        @(negedge clk);
        chk("irq_pop1", irq, 0);
        @(negedge clk);
        ready = 0;
        chk("irq_pop2", irq, 1);
        wr(4'h0, 32'd500);
        chk("irq_refill", irq, 0);
`else
        wr(4'h8, 32'h4);
        chk("irq_tied", irq, 0);
        rd(4'h4, r);
        chk("irq_en_ignored", r, 32'h0001_0000);
        for (int i = 0; i < 3; i++) wr(4'h0, 32'(400 + i));
        chk("irq_tied_low", irq, 0);
`endif

        // reset during an in-flight read
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h4;
        #2 rst_n = 0;
        @(negedge clk);
        chk("midrst_ack", ack, 0);
        chk("midrst_valid", valid, 0);
        stb = 0; cyc = 0;
        @(negedge clk);
        rst_n = 1;
        rd(4'h4, r);
        chk("midrst_status", r, 32'h0001_0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
